// File: rtl/little_computer_soc_pkg.sv
// Shared ISA definitions for the little-computer: opcodes, ALU functions and instruction layout.
package little_computer_soc_pkg;

    localparam int unsigned DataWidth = 16;
    localparam int unsigned NumRegs   = 8;

    localparam logic [3:0] OpHalt = 4'd0;
    localparam logic [3:0] OpAlu  = 4'd1;
    localparam logic [3:0] OpAddi = 4'd2;
    localparam logic [3:0] OpLw   = 4'd3;
    localparam logic [3:0] OpSw   = 4'd4;
    localparam logic [3:0] OpBeq  = 4'd5;
    localparam logic [3:0] OpJ    = 4'd6;

    typedef enum logic [2:0] {
        FnAdd, FnSub, FnAnd, FnOr, FnXor, FnNor, FnSlt, FnSll
    } alu_fn_e;

    // a = rd/rt [11:9], b = rs [8:6], c = R-type rt [5:3]; {c, fn} is imm6, {a, b, c, fn} addr12
    typedef struct packed {
        logic [3:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] c;
        logic [2:0] fn;
    } instr_t;

    function automatic logic [DataWidth-1:0] sext6(input logic [5:0] imm);
        return {{(DataWidth - 6){imm[5]}}, imm};
    endfunction

endpackage

// File: rtl/little_computer_soc_cpu.sv
// Single-cycle 16-bit CPU; state commits only on i_commit and freezes while the fetched op is HALT.
module cpu
    import little_computer_soc_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_commit,
    output logic [AW-1:0]        o_imem_addr,
    input  logic [DataWidth-1:0] i_imem_data,
    output logic [AW-1:0]        o_dmem_addr,
    input  logic [DataWidth-1:0] i_dmem_data,
    output logic                 o_dmem_we,
    output logic [DataWidth-1:0] o_dmem_wdata,
    output logic [9:0]           o_led
);

    logic [DataWidth-1:0] pc;
    logic                 halted;
    instr_t               w_ins;
    logic                 w_step;
    logic [2:0]           w_rt_sel;
    logic [DataWidth-1:0] w_rs_val, w_rt_val, w_simm, w_sum, w_alu;
    logic [DataWidth-1:0] w_pc_inc, w_pc_next, w_rf_wdata;
    logic                 w_rf_we;

    assign w_ins    = instr_t'(i_imem_data);
    assign halted   = (w_ins.op == OpHalt);
    assign w_step   = i_commit && !halted;
    assign w_rt_sel = (w_ins.op == OpAlu) ? w_ins.c : w_ins.a;
    assign w_simm   = sext6({w_ins.c, w_ins.fn});
    assign w_sum    = w_rs_val + w_simm;
    assign w_pc_inc = pc + DataWidth'(1);

    registers registers_c (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (w_rf_we),
        .i_waddr   (w_ins.a),
        .i_wdata   (w_rf_wdata),
        .i_raddr_a (w_ins.b),
        .o_rdata_a (w_rs_val),
        .i_raddr_b (w_rt_sel),
        .o_rdata_b (w_rt_val),
        .o_led     (o_led)
    );

    always_comb begin
        w_alu = '0;
        unique case (alu_fn_e'(w_ins.fn))
            FnAdd:   w_alu = w_rs_val + w_rt_val;
            FnSub:   w_alu = w_rs_val - w_rt_val;
            FnAnd:   w_alu = w_rs_val & w_rt_val;
            FnOr:    w_alu = w_rs_val | w_rt_val;
            FnXor:   w_alu = w_rs_val ^ w_rt_val;
            FnNor:   w_alu = ~(w_rs_val | w_rt_val);
            FnSlt:   w_alu = {{(DataWidth - 1){1'b0}}, $signed(w_rs_val) < $signed(w_rt_val)};
            FnSll:   w_alu = w_rs_val << w_rt_val[3:0];
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_wdata = w_sum;
        case (w_ins.op)
            OpAlu: begin
                w_rf_we    = w_step;
                w_rf_wdata = w_alu;
            end
            OpAddi: w_rf_we = w_step;
            OpLw: begin
                w_rf_we    = w_step;
                w_rf_wdata = i_dmem_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_ins.op)
            OpBeq: if (w_rs_val == w_rt_val) w_pc_next = w_pc_inc + w_simm;
            OpJ:   w_pc_next = {4'd0, w_ins.a, w_ins.b, w_ins.c, w_ins.fn};
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc <= '0;
        end else if (w_step) begin
            pc <= w_pc_next;
        end
    end

    assign o_imem_addr  = pc[AW-1:0];
    assign o_dmem_addr  = w_sum[AW-1:0];
    assign o_dmem_we    = w_step && (w_ins.op == OpSw);
    assign o_dmem_wdata = w_rt_val;

endmodule

// File: rtl/little_computer_soc_memory.sv
// Unified instruction/data memory: two combinational read ports, one synchronous write port.
module memory
    import little_computer_soc_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic                 i_clk,
    input  logic [AW-1:0]        i_raddr_a,
    output logic [DataWidth-1:0] o_rdata_a,
    input  logic [AW-1:0]        i_raddr_b,
    output logic [DataWidth-1:0] o_rdata_b,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic [DataWidth-1:0] i_wdata
);

    // Not reset: programs are preloaded and must survive reset.
    logic [DataWidth-1:0] mem [0:MEM_WORDS-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = mem[i_raddr_a];
    assign o_rdata_b = mem[i_raddr_b];

endmodule

// File: rtl/little_computer_soc_registers.sv
// Eight-entry register file; r0 is never written so it always reads zero.
module registers
    import little_computer_soc_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic [2:0]           i_waddr,
    input  logic [DataWidth-1:0] i_wdata,
    input  logic [2:0]           i_raddr_a,
    output logic [DataWidth-1:0] o_rdata_a,
    input  logic [2:0]           i_raddr_b,
    output logic [DataWidth-1:0] o_rdata_b,
    output logic [9:0]           o_led
);

    logic [DataWidth-1:0] reg_file [0:NumRegs-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                reg_file[i] <= '0;
            end
        end else if (i_we && (i_waddr != 3'd0)) begin
            reg_file[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = reg_file[i_raddr_a];
    assign o_rdata_b = reg_file[i_raddr_b];
    assign o_led     = reg_file[1][9:0];

endmodule

// File: rtl/little_computer_soc.sv
// Little-computer top: board-clock divider pacing a single-cycle CPU over a unified memory.
module little_computer_soc
    import little_computer_soc_pkg::*;
#(
    parameter int unsigned CPU_CLK_DIV_WIDTH = 2,
    parameter int unsigned MEM_WORDS         = 1024
) (
    input  logic       MAX10_CLK1_50,
    input  logic       RST,
    input  logic [9:0] SW,
    output logic [9:0] LEDR
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [CPU_CLK_DIV_WIDTH-1:0] r_div;
    logic                         w_commit;
    logic [AW-1:0]                w_imem_addr, w_dmem_addr;
    logic [DataWidth-1:0]         w_imem_data, w_dmem_data, w_dmem_wdata;
    logic                         w_dmem_we;
    logic                         w_unused_sw;

    assign w_unused_sw = ^SW;

    always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
        if (RST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // The edge on which the divider wraps to zero is the CPU commit edge.
    assign w_commit = &r_div;

    cpu #(
        .AW (AW)
    ) cpu_c (
        .i_clk        (MAX10_CLK1_50),
        .i_rst        (RST),
        .i_commit     (w_commit),
        .o_imem_addr  (w_imem_addr),
        .i_imem_data  (w_imem_data),
        .o_dmem_addr  (w_dmem_addr),
        .i_dmem_data  (w_dmem_data),
        .o_dmem_we    (w_dmem_we),
        .o_dmem_wdata (w_dmem_wdata),
        .o_led        (LEDR)
    );

    memory #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) memory_c (
        .i_clk     (MAX10_CLK1_50),
        .i_raddr_a (w_imem_addr),
        .o_rdata_a (w_imem_data),
        .i_raddr_b (w_dmem_addr),
        .o_rdata_b (w_dmem_data),
        .i_we      (w_dmem_we),
        .i_waddr   (w_dmem_addr),
        .i_wdata   (w_dmem_wdata)
    );

endmodule

// File: tb/tb_little_computer_soc.sv
// Bench for little_computer_soc: instruction-level reference model checked every CPU cycle.
module tb_little_computer_soc;

    localparam int Div = 4;
    localparam int MemWords = 1024;

    logic       clk;
    logic       rst;
    logic [9:0] sw;
    logic [9:0] ledr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_mem [0:MemWords-1];
    logic [15:0] m_reg [0:7];
    logic [15:0] m_pc;

    little_computer_soc #(
        .CPU_CLK_DIV_WIDTH (2),
        .MEM_WORDS         (MemWords)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .RST           (rst),
        .SW            (sw),
        .LEDR          (ledr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] rt,
                                       input logic [2:0] rs, input int imm);
        logic [15:0] t;
        t = 16'(imm);
        return {op, rt, rs, t[5:0]};
    endfunction

    function automatic logic [15:0] rr(input logic [2:0] fn, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt);
        return {4'd1, rd, rs, rt, fn};
    endfunction

    function automatic logic [15:0] jj(input int addr);
        logic [15:0] t;
        t = 16'(addr);
        return {4'd6, t[11:0]};
    endfunction

    function automatic logic [15:0] dreg(input int i);
        return dut.cpu_c.registers_c.reg_file[i];
    endfunction

    function automatic logic m_halted();
        logic [15:0] w;
        w = m_mem[m_pc[9:0]];
        return w[15:12] == 4'd0;
    endfunction

    // Reference: execute one instruction at architectural level
    task automatic model_step();
        logic [15:0] ins, a, b, s, ea, res;
        logic [2:0]  rt;
        ins = m_mem[m_pc[9:0]];
        if (ins[15:12] == 4'd0) return;
        a  = m_reg[ins[8:6]];
        rt = ins[11:9];
        s  = {{10{ins[5]}}, ins[5:0]};
        ea = a + s;
        res = 16'h0;
        case (int'(ins[15:12]))
            1: begin
                b = m_reg[ins[5:3]];
                case (int'(ins[2:0]))
                    0: res = a + b;
                    1: res = a - b;
                    2: res = a & b;
                    3: res = a | b;
                    4: res = a ^ b;
                    5: res = ~(a | b);
                    6: res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                    default: res = a << b[3:0];
                endcase
                if (rt != 0) m_reg[rt] = res;
                m_pc = m_pc + 16'd1;
            end
            2: begin
                if (rt != 0) m_reg[rt] = ea;
                m_pc = m_pc + 16'd1;
            end
            3: begin
                if (rt != 0) m_reg[rt] = m_mem[ea[9:0]];
                m_pc = m_pc + 16'd1;
            end
            4: begin
                m_mem[ea[9:0]] = m_reg[rt];
                m_pc = m_pc + 16'd1;
            end
            5: m_pc = (a == m_reg[rt]) ? m_pc + 16'd1 + s : m_pc + 16'd1;
            6: m_pc = {4'd0, ins[11:0]};
            default: m_pc = m_pc + 16'd1;
        endcase
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pc"}, dut.cpu_c.pc, m_pc);
        chk({tag, ".halted"}, dut.cpu_c.halted, m_halted());
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s.r%0d", tag, i), dreg(i), m_reg[i]);
        end
        chk({tag, ".ledr"}, ledr, m_reg[1][9:0]);
    endtask

    task automatic check_mem(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < MemWords; i++) begin
            if (dut.memory_c.mem[i] !== m_mem[i]) bad++;
        end
        chk({tag, ".mem_mismatches"}, bad, 0);
    endtask

    task automatic put(input int addr, input logic [15:0] v);
        m_mem[addr] = v;
        dut.memory_c.mem[addr] = v;
    endtask

    task automatic assert_reset_and_clear();
        rst = 1'b1;
        #1;
        for (int i = 0; i < MemWords; i++) put(i, 16'h0000);
    endtask

    task automatic model_reset();
        m_pc = 16'h0;
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
    endtask

    task automatic release_reset(input string tag);
        model_reset();
        #1;
        check_state({tag, ".rst"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One CPU cycle; pc must not move before the commit edge
    task automatic run_cycle(input string tag);
        repeat (Div - 1) @(posedge clk);
        #1;
        chk({tag, ".pc_precommit"}, dut.cpu_c.pc, m_pc);
        @(posedge clk);
        #1;
        model_step();
        check_state(tag);
    endtask

    task automatic run_to_halt(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!m_halted() && n < max_cycles) begin
            run_cycle($sformatf("%s.c%0d", tag, n));
            n++;
        end
        if (!m_halted()) chk({tag, ".halt_budget"}, 0, 1);
        run_cycle({tag, ".hold1"});
        run_cycle({tag, ".hold2"});
        check_mem(tag);
    endtask

    initial begin
        sw  = 10'h2A5;
        rst = 1'b1;

        // HALT at address 0
        assert_reset_and_clear();
        put(0, 16'h0000);
        release_reset("p1");
        chk("p1.pc_pre", dut.cpu_c.pc, 0);
        chk("p1.halted_pre", dut.cpu_c.halted, 1);
        run_cycle("p1.c1");
        chk("p1.pc_c1", dut.cpu_c.pc, 0);
        chk("p1.halted_c1", dut.cpu_c.halted, 1);

        // ADDI / NOP sequence with negative immediate
        assert_reset_and_clear();
        put(0, ri(4'd2, 3'd1, 3'd0, 1));
        put(1, 16'h7000);
        put(2, ri(4'd2, 3'd1, 3'd1, 1));
        put(3, ri(4'd2, 3'd1, 3'd0, -30));
        put(4, ri(4'd2, 3'd1, 3'd0, 1));
        put(5, 16'h0000);
        release_reset("p2");
        run_cycle("p2.c1");
        chk("p2.c1_pc", dut.cpu_c.pc, 1);
        chk("p2.c1_r1", dreg(1), 16'h0001);
        run_cycle("p2.c2");
        chk("p2.c2_pc", dut.cpu_c.pc, 2);
        chk("p2.c2_r1", dreg(1), 16'h0001);
        run_cycle("p2.c3");
        chk("p2.c3_r1", dreg(1), 16'h0002);
        run_cycle("p2.c4");
        chk("p2.c4_r1", dreg(1), 16'hFFE2);
        run_cycle("p2.c5");
        chk("p2.c5_halted", dut.cpu_c.halted, 1);
        chk("p2.c5_r1", dreg(1), 16'h0001);
        chk("p2.c5_ledr", ledr, 10'h001);
        run_cycle("p2.hold");
        chk("p2.hold_pc", dut.cpu_c.pc, 5);

        // ALU chain
        assert_reset_and_clear();
        put(0,  ri(4'd2, 3'd2, 3'd0, 5));
        put(1,  ri(4'd2, 3'd3, 3'd0, 12));
        put(2,  rr(3'd1, 3'd4, 3'd2, 3'd3));
        put(3,  rr(3'd2, 3'd5, 3'd3, 3'd2));
        put(4,  rr(3'd3, 3'd6, 3'd5, 3'd2));
        put(5,  rr(3'd6, 3'd7, 3'd4, 3'd2));
        put(6,  rr(3'd1, 3'd1, 3'd4, 3'd7));
        put(7,  rr(3'd1, 3'd1, 3'd1, 3'd7));
        put(8,  rr(3'd4, 3'd5, 3'd3, 3'd2));
        put(9,  rr(3'd5, 3'd6, 3'd3, 3'd2));
        put(10, rr(3'd7, 3'd7, 3'd7, 3'd2));
        put(11, rr(3'd6, 3'd2, 3'd2, 3'd4));
        put(12, rr(3'd0, 3'd3, 3'd3, 3'd3));
        put(13, 16'h0000);
        release_reset("p3");
        run_to_halt("p3", 40);
        chk("p3.r1", dreg(1), 16'hFFF7);
        chk("p3.r2", dreg(2), 16'h0000);
        chk("p3.r3", dreg(3), 16'h0018);
        chk("p3.r4", dreg(4), 16'hFFF9);
        chk("p3.r5", dreg(5), 16'h0009);
        chk("p3.r6", dreg(6), 16'hFFF2);
        chk("p3.r7", dreg(7), 16'h0020);
        chk("p3.ledr", ledr, 10'h3F7);

        // Mid-program, mid-divider reset; same ALU program re-runs
        rst = 1'b1;
        release_reset("p6");
        for (int i = 0; i < 4; i++) run_cycle($sformatf("p6.pre%0d", i));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("p6.async_pc", dut.cpu_c.pc, 0);
        chk("p6.async_r2", dreg(2), 0);
        chk("p6.async_r4", dreg(4), 0);
        chk("p6.async_ledr", ledr, 0);
        chk("p6.async_halted", dut.cpu_c.halted, 0);
        release_reset("p6b");
        run_to_halt("p6b", 40);
        chk("p6b.r1", dreg(1), 16'hFFF7);
        chk("p6b.r7", dreg(7), 16'h0020);

        // Branches: not taken, forward taken, backward taken; write to r0 dropped
        assert_reset_and_clear();
        put(0, ri(4'd2, 3'd2, 3'd0, 5));
        put(1, ri(4'd5, 3'd2, 3'd0, 3));
        put(2, ri(4'd2, 3'd1, 3'd0, 3));
        put(3, ri(4'd5, 3'd0, 3'd0, 2));
        put(4, ri(4'd2, 3'd1, 3'd1, 5));
        put(5, jj(8));
        put(6, ri(4'd2, 3'd0, 3'd0, 7));
        put(7, ri(4'd5, 3'd0, 3'd0, -4));
        put(8, 16'h0000);
        release_reset("p4");
        run_to_halt("p4", 30);
        chk("p4.r1", dreg(1), 16'h0008);
        chk("p4.r2", dreg(2), 16'h0005);
        chk("p4.r0", dreg(0), 16'h0000);
        chk("p4.pc", dut.cpu_c.pc, 8);

        // J over an ADDI, then pc increment past the top of memory
        assert_reset_and_clear();
        put(0, ri(4'd5, 3'd3, 3'd0, 1));
        put(1, 16'h0000);
        put(2, ri(4'd2, 3'd1, 3'd0, 1));
        put(3, jj(5));
        put(4, ri(4'd2, 3'd1, 3'd0, 2));
        put(5, jj(1023));
        put(1023, ri(4'd2, 3'd3, 3'd0, 4));
        release_reset("p7");
        run_to_halt("p7", 30);
        chk("p7.r1", dreg(1), 16'h0001);
        chk("p7.r3", dreg(3), 16'h0004);
        chk("p7.pc", dut.cpu_c.pc, 16'h0401);

        // Data memory: LW preload, SW then LW next cycle, negative-offset wrap
        assert_reset_and_clear();
        put(0, ri(4'd3, 3'd1, 3'd0, 20));
        put(1, ri(4'd2, 3'd2, 3'd1, 1));
        put(2, ri(4'd4, 3'd2, 3'd0, 31));
        put(3, ri(4'd3, 3'd3, 3'd0, 31));
        put(4, ri(4'd2, 3'd2, 3'd0, 0));
        put(5, ri(4'd3, 3'd2, 3'd0, 31));
        put(6, ri(4'd3, 3'd4, 3'd0, -1));
        put(7, 16'h0000);
        put(20, 16'h6001);
        put(1023, 16'hABCD);
        release_reset("p5");
        run_to_halt("p5", 30);
        chk("p5.r1", dreg(1), 16'h6001);
        chk("p5.r2", dreg(2), 16'h6002);
        chk("p5.r3", dreg(3), 16'h6002);
        chk("p5.r4", dreg(4), 16'hABCD);
        chk("p5.mem31", dut.memory_c.mem[31], 16'h6002);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
